pkt_frame_ctrl_mp: RTL and testbench

- Multi-port packet-framing controller; next generation of the single-port control FSM.
- Tracks val/sop/eop framing on NUM_PORTS independent ingress ports.
- Gates each port's enable at packet boundaries and detects orphan-EOP, nested-SOP and over-length packets.
- Keeps per-port sticky error cause and saturating error counters. Sits between the port interfaces and the ingress datapath.

---
 rtl/pkt_frame_ctrl_mp_if.sv | 11 +
 rtl/pkt_frame_ctrl_mp.sv | 149 ++++++++++++++
 tb/tb_pkt_frame_ctrl_mp.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_frame_ctrl_mp_if.sv
// Ingress framing bus shared by all ports: per-port beat valid, start and end of packet.
interface pkt_frame_ctrl_mp_if #(
    parameter int unsigned NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0] val;
    logic [NUM_PORTS-1:0] sop;
    logic [NUM_PORTS-1:0] eop;

    modport master (output val, sop, eop);
    modport slave  (input  val, sop, eop);
endinterface

// File: rtl/pkt_frame_ctrl_mp.sv
// Multi-port packet framing controller: per-port framing FSM, boundary-gated enable,
// orphan/nested/over-length detection with sticky cause and saturating error counters.
module pkt_frame_ctrl_mp #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned MAX_LEN   = 64,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic [NUM_PORTS-1:0]           cfg_port_enable,
    input  logic                           cfg_len_chk_en,
    pkt_frame_ctrl_mp_if.slave             ing,
    input  logic [NUM_PORTS-1:0]           err_clr,
    output logic [NUM_PORTS-1:0]           enable,
    output logic [NUM_PORTS-1:0]           error,
    output logic [NUM_PORTS-1:0]           in_pkt,
    output logic [3*NUM_PORTS-1:0]         err_cause,
    output logic [ERR_CNT_W*NUM_PORTS-1:0] err_cnt
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [2:0]           C_ORPHAN  = 3'b001;
    localparam logic [2:0]           C_NESTED  = 3'b010;
    localparam logic [2:0]           C_OVERLEN = 3'b100;
    localparam logic [LEN_W-1:0]     LEN_LAST  = LEN_W'(MAX_LEN - 1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_WAIT_EOP,
        ST_ERROR,
        ST_DRAIN
    } state_e;

    state_e                         state_q [NUM_PORTS];
    state_e                         state_d [NUM_PORTS];
    logic [LEN_W-1:0]               len_q   [NUM_PORTS];
    logic [LEN_W-1:0]               len_d   [NUM_PORTS];
    logic [2:0]                     new_cause [NUM_PORTS];
    logic [NUM_PORTS-1:0]           enable_d;
    logic [NUM_PORTS-1:0]           error_d;
    logic [NUM_PORTS-1:0]           in_pkt_d;
    logic [3*NUM_PORTS-1:0]         cause_d;
    logic [ERR_CNT_W*NUM_PORTS-1:0] cnt_d;
    logic [NUM_PORTS-1:0]           sop_i;
    logic [NUM_PORTS-1:0]           eop_i;

    assign sop_i = ing.val & ing.sop;
    assign eop_i = ing.val & ing.eop;

    // Next-state, beat count, and next values of the registered outputs, per port.
    always_comb begin
        enable_d = enable;
        error_d  = '0;
        in_pkt_d = '0;
        cause_d  = err_cause;
        cnt_d    = err_cnt;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            state_d[p]   = state_q[p];
            len_d[p]     = len_q[p];
            new_cause[p] = 3'b000;

            case (state_q[p])
                ST_RESET: state_d[p] = ST_IDLE;
                ST_IDLE: begin
                    if (eop_i[p] && !sop_i[p]) begin
                        state_d[p]   = ST_ERROR;
                        new_cause[p] = C_ORPHAN;
                    end else if (sop_i[p] && !eop_i[p]) begin
                        state_d[p] = ST_WAIT_EOP;
                        len_d[p]   = LEN_W'(1);
                    end
                end
                ST_WAIT_EOP: begin
                    if (sop_i[p]) begin
                        state_d[p]   = ST_ERROR;
                        new_cause[p] = C_NESTED;
                    end else if (eop_i[p]) begin
                        state_d[p] = ST_IDLE;
                    end else if (ing.val[p]) begin
                        if (cfg_len_chk_en && len_q[p] == LEN_LAST) begin
                            state_d[p]   = ST_DRAIN;
                            new_cause[p] = C_OVERLEN;
                        end else if (len_q[p] != LEN_LAST) begin
                            len_d[p] = len_q[p] + LEN_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sop_i[p]) begin
                        state_d[p]   = ST_ERROR;
                        new_cause[p] = C_NESTED;
                    end else if (eop_i[p]) begin
                        state_d[p] = ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    if (eop_i[p] && !sop_i[p]) begin
                        new_cause[p] = C_ORPHAN;
                    end else if (sop_i[p] && !eop_i[p]) begin
                        state_d[p] = ST_WAIT_EOP;
                        len_d[p]   = LEN_W'(1);
                    end else begin
                        state_d[p] = ST_IDLE;
                    end
                end
                default: state_d[p] = ST_IDLE;
            endcase

            error_d[p]  = |new_cause[p];
            in_pkt_d[p] = (state_d[p] == ST_WAIT_EOP) || (state_d[p] == ST_DRAIN);
            // Enable only follows config when the port lands between packets.
            if (state_d[p] == ST_IDLE || state_d[p] == ST_ERROR) begin
                enable_d[p] = cfg_port_enable[p];
            end
            cause_d[p*3 +: 3] = (err_clr[p] ? 3'b000 : err_cause[p*3 +: 3]) | new_cause[p];
            if (err_clr[p]) begin
                cnt_d[p*ERR_CNT_W +: ERR_CNT_W] = ERR_CNT_W'(error_d[p]);
            end else if (error_d[p] && err_cnt[p*ERR_CNT_W +: ERR_CNT_W] != CNT_MAX) begin
                cnt_d[p*ERR_CNT_W +: ERR_CNT_W] = err_cnt[p*ERR_CNT_W +: ERR_CNT_W] + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                state_q[p] <= ST_RESET;
                len_q[p]   <= '0;
            end
            enable    <= '0;
            error     <= '0;
            in_pkt    <= '0;
            err_cause <= '0;
            err_cnt   <= '0;
        end else begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                state_q[p] <= state_d[p];
                len_q[p]   <= len_d[p];
            end
            enable    <= enable_d;
            error     <= error_d;
            in_pkt    <= in_pkt_d;
            err_cause <= cause_d;
            err_cnt   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pkt_frame_ctrl_mp.sv
// Scenario bench for pkt_frame_ctrl_mp: a 4-port default instance and a 1-port instance
// with MAX_LEN=4, ERR_CNT_W=2; per-beat expectations are queued at drive time.
module tb_pkt_frame_ctrl_mp;
    logic        clk = 1'b0;
    logic        reset_L;
    logic        len_chk;
    logic [3:0]  cfg_a, clr_a, en_a, err_a, inp_a;
    logic [11:0] cause_a;
    logic [31:0] cnt_a;
    logic [0:0]  cfg_b, clr_b, en_b, err_b, inp_b;
    logic [2:0]  cause_b;
    logic [1:0]  cnt_b;

    typedef struct {
        string       name;
        logic [13:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    pkt_frame_ctrl_mp_if #(.NUM_PORTS(4)) ifa ();
    pkt_frame_ctrl_mp_if #(.NUM_PORTS(1)) ifb ();

    pkt_frame_ctrl_mp #(.NUM_PORTS(4), .MAX_LEN(64), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .reset_L(reset_L), .cfg_port_enable(cfg_a), .cfg_len_chk_en(len_chk),
        .ing(ifa), .err_clr(clr_a), .enable(en_a), .error(err_a), .in_pkt(inp_a),
        .err_cause(cause_a), .err_cnt(cnt_a));

    pkt_frame_ctrl_mp #(.NUM_PORTS(1), .MAX_LEN(4), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .reset_L(reset_L), .cfg_port_enable(cfg_b), .cfg_len_chk_en(len_chk),
        .ing(ifb), .err_clr(clr_b), .enable(en_b), .error(err_b), .in_pkt(inp_b),
        .err_cause(cause_b), .err_cnt(cnt_b));

    // Expected per-port tuple {error, in_pkt, enable, cause[2:0], cnt[7:0]}.
    function automatic logic [13:0] mk(input logic er, input logic ip, input logic en,
                                       input logic [2:0] c, input logic [7:0] k);
        return {er, ip, en, c, k};
    endfunction

    function automatic logic [13:0] obs_a(input int p);
        return {err_a[p], inp_a[p], en_a[p], cause_a[p*3 +: 3], cnt_a[p*8 +: 8]};
    endfunction

    function automatic logic [13:0] obs_b();
        return {err_b[0], inp_b[0], en_b[0], cause_b, {6'b0, cnt_b}};
    endfunction

    task automatic drive_a(input int p, input logic v, input logic s, input logic e,
                           input logic [13:0] x, input string nm);
        ifa.val[p] = v;
        ifa.sop[p] = s;
        ifa.eop[p] = e;
        exp_q.push_back('{nm, x});
        @(posedge clk);
        #1;
        ifa.val = '0;
        ifa.sop = '0;
        ifa.eop = '0;
    endtask

    task automatic drive_b(input logic v, input logic s, input logic e, input logic clr,
                           input logic [13:0] x, input string nm);
        ifb.val[0] = v;
        ifb.sop[0] = s;
        ifb.eop[0] = e;
        clr_b[0]   = clr;
        exp_q.push_back('{nm, x});
        @(posedge clk);
        #1;
        ifb.val = '0;
        ifb.sop = '0;
        ifb.eop = '0;
        clr_b   = '0;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        cfg_a = 4'hF; clr_a = '0; cfg_b = 1'b1; clr_b = '0; len_chk = 1'b1;
        ifa.val = '0; ifa.sop = '0; ifa.eop = '0;
        ifb.val = '0; ifb.sop = '0; ifb.eop = '0;
        #12;
        checks++;
        if ({en_a, err_a, inp_a, cause_a, cnt_a} !== 56'd0)
            $display("FAIL reset_a: got %h want 0", {en_a, err_a, inp_a, cause_a, cnt_a});
        else passed++;
        checks++;
        if ({en_b, err_b, inp_b, cause_b, cnt_b} !== 8'd0)
            $display("FAIL reset_b: got %h want 0", {en_b, err_b, inp_b, cause_b, cnt_b});
        else passed++;
        @(negedge clk);
        reset_L = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({en_a, err_a, cnt_a} !== {4'hF, 4'h0, 32'd0})
            $display("FAIL enable_after_reset: got en=%b err=%b cnt=%h want en=1111 err=0 cnt=0",
                     en_a, err_a, cnt_a);
        else passed++;
        checks++;
        if ({en_b, err_b, inp_b} !== 3'b100)
            $display("FAIL enable_after_reset_b: got %b want 100", {en_b, err_b, inp_b});
        else passed++;
    endtask

    task automatic test_single_packet();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive_a(0, 1'b1, i == 0, i == 4, mk(1'b0, i != 4, 1'b1, 3'b000, 8'd0),
                    $sformatf("pkt5 beat %0d", i));
            e = exp_q.pop_front(); checks++;
            if (obs_a(0) !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_a(0), e.val);
            else passed++;
        end
        drive_a(0, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b1, 3'b000, 8'd0), "single_beat");
        e = exp_q.pop_front(); checks++;
        if (obs_a(0) !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_a(0), e.val);
        else passed++;
    endtask

    task automatic test_orphan_eop();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive_a(1, i < 2, 1'b0, i < 2,
                    mk(i < 2, 1'b0, 1'b1, 3'b001, (i == 0) ? 8'd1 : 8'd2),
                    $sformatf("orphan %0d", i));
            e = exp_q.pop_front(); checks++;
            if (obs_a(1) !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_a(1), e.val);
            else passed++;
        end
    endtask

    task automatic test_over_length();
        exp_t e;
        // 64 beats without eop: the 64th trips the limit and enters DRAIN.
        for (int i = 0; i < 66; i++) begin
            drive_a(2, 1'b1, i == 0, i == 65,
                    mk(i == 63, i != 65, 1'b1, (i >= 63) ? 3'b100 : 3'b000, (i >= 63) ? 8'd1 : 8'd0),
                    $sformatf("ovl beat %0d", i));
            e = exp_q.pop_front(); checks++;
            if (obs_a(2) !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_a(2), e.val);
            else passed++;
        end
        for (int i = 0; i < 64; i++) begin
            drive_a(2, 1'b1, i == 0, i == 63, mk(1'b0, i != 63, 1'b1, 3'b100, 8'd1),
                    $sformatf("max_len beat %0d", i));
            e = exp_q.pop_front(); checks++;
            if (obs_a(2) !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_a(2), e.val);
            else passed++;
        end
        len_chk = 1'b0;
        for (int i = 0; i < 72; i++) begin
            drive_a(2, 1'b1, i == 0, i == 71, mk(1'b0, i != 71, 1'b1, 3'b100, 8'd1),
                    $sformatf("nochk beat %0d", i));
            e = exp_q.pop_front(); checks++;
            if (obs_a(2) !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_a(2), e.val);
            else passed++;
        end
        len_chk = 1'b1;
        // Over-length again, then a sop while draining is a nested error.
        for (int i = 0; i < 66; i++) begin
            drive_a(2, i < 65, i == 0 || i == 64, 1'b0,
                    (i < 63) ? mk(1'b0, 1'b1, 1'b1, 3'b100, 8'd1) :
                    (i == 63) ? mk(1'b1, 1'b1, 1'b1, 3'b100, 8'd2) :
                    (i == 64) ? mk(1'b1, 1'b0, 1'b1, 3'b110, 8'd3) :
                                mk(1'b0, 1'b0, 1'b1, 3'b110, 8'd3),
                    $sformatf("drain_sop beat %0d", i));
            e = exp_q.pop_front(); checks++;
            if (obs_a(2) !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_a(2), e.val);
            else passed++;
        end
    endtask

    task automatic test_nested_and_enable();
        exp_t e;
        logic [2:0] stim [9];
        logic [13:0] xp [9];
        stim = '{3'b110, 3'b100, 3'b110, 3'b110, 3'b100, 3'b100, 3'b101, 3'b000, 3'b000};
        xp   = '{mk(1'b0, 1'b1, 1'b1, 3'b000, 8'd0), mk(1'b0, 1'b1, 1'b1, 3'b000, 8'd0),
                 mk(1'b1, 1'b0, 1'b1, 3'b010, 8'd1), mk(1'b0, 1'b1, 1'b1, 3'b010, 8'd1),
                 mk(1'b0, 1'b1, 1'b1, 3'b010, 8'd1), mk(1'b0, 1'b1, 1'b1, 3'b010, 8'd1),
                 mk(1'b0, 1'b0, 1'b0, 3'b010, 8'd1), mk(1'b0, 1'b0, 1'b0, 3'b010, 8'd1),
                 mk(1'b0, 1'b0, 1'b1, 3'b010, 8'd1)};
        for (int i = 0; i < 9; i++) begin
            if (i == 4) cfg_a[3] = 1'b0;
            if (i == 8) cfg_a[3] = 1'b1;
            drive_a(3, stim[i][2], stim[i][1], stim[i][0], xp[i], $sformatf("nested step %0d", i));
            e = exp_q.pop_front(); checks++;
            if (obs_a(3) !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_a(3), e.val);
            else passed++;
        end
        checks++;
        if (obs_a(0) !== mk(1'b0, 1'b0, 1'b1, 3'b000, 8'd0))
            $display("FAIL port0_isolated: got %b want %b", obs_a(0), mk(1'b0, 1'b0, 1'b1, 3'b000, 8'd0));
        else passed++;
    endtask

    task automatic test_saturate_and_clear();
        exp_t e;
        drive_b(1'b1, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b1, 1'b1, 3'b000, 8'd0), "b_sop");
        e = exp_q.pop_front(); checks++;
        if (obs_b() !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_b(), e.val);
        else passed++;
        drive_b(1'b1, 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b1, 3'b010, 8'd1), "b_nested");
        e = exp_q.pop_front(); checks++;
        if (obs_b() !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_b(), e.val);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            drive_b(1'b1, 1'b0, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b1, 3'b011, (i == 0) ? 8'd2 : 8'd3),
                    $sformatf("b_orphan %0d", i));
            e = exp_q.pop_front(); checks++;
            if (obs_b() !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_b(), e.val);
            else passed++;
        end
        drive_b(1'b1, 1'b0, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b1, 3'b001, 8'd1), "b_clr_with_err");
        e = exp_q.pop_front(); checks++;
        if (obs_b() !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_b(), e.val);
        else passed++;
        drive_b(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b1, 3'b000, 8'd0), "b_clr_only");
        e = exp_q.pop_front(); checks++;
        if (obs_b() !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_b(), e.val);
        else passed++;
    endtask

    task automatic test_reset_mid_packet();
        exp_t e;
        // MAX_LEN=4 instance: 4th beat without eop enters DRAIN.
        for (int i = 0; i < 4; i++) begin
            drive_b(1'b1, i == 0, 1'b0, 1'b0,
                    (i == 3) ? mk(1'b1, 1'b1, 1'b1, 3'b100, 8'd1) : mk(1'b0, 1'b1, 1'b1, 3'b000, 8'd0),
                    $sformatf("b_ovl beat %0d", i));
            e = exp_q.pop_front(); checks++;
            if (obs_b() !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_b(), e.val);
            else passed++;
        end
        drive_a(0, 1'b1, 1'b1, 1'b0, mk(1'b0, 1'b1, 1'b1, 3'b000, 8'd0), "a_open_pkt");
        e = exp_q.pop_front(); checks++;
        if (obs_a(0) !== e.val) $display("FAIL %s: got %b want %b", e.name, obs_a(0), e.val);
        else passed++;
        #2;
        reset_L = 1'b0;
        #1;
        checks++;
        if ({en_a, err_a, inp_a, cause_a, cnt_a} !== 56'd0)
            $display("FAIL async_reset_a: got %h want 0", {en_a, err_a, inp_a, cause_a, cnt_a});
        else passed++;
        checks++;
        if ({en_b, err_b, inp_b, cause_b, cnt_b} !== 8'd0)
            $display("FAIL async_reset_b: got %h want 0", {en_b, err_b, inp_b, cause_b, cnt_b});
        else passed++;
        @(negedge clk);
        reset_L = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({err_a, inp_a, en_a, cnt_a} !== {4'h0, 4'h0, 4'hF, 32'd0})
            $display("FAIL no_err_after_reset: got err=%b in=%b en=%b cnt=%h want 0 0 1111 0",
                     err_a, inp_a, en_a, cnt_a);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_orphan_eop();
        test_over_length();
        test_nested_and_enable();
        test_saturate_and_clear();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d so far", passed, checks);
        $fatal(1);
    end
endmodule
